// File: rtl/ddc_mixer_lanes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddc_mixer_pkg
// Description : Shared types and helpers for the multi-lane NCO mixer:
//               mode encoding, pipeline latency and quarter-wave LUT entries.
// Revision    : 1.0 - initial release
// ============================================================================
package ddc_mixer_pkg;

    typedef enum logic [1:0] {
        MODE_DOWN   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_BYPASS = 2'b10
    } mode_e;

    localparam int LATENCY = 5;

    // Raw mode field to enum; the unused code 2'b11 behaves as bypass.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b00:   return MODE_DOWN;
            2'b01:   return MODE_UP;
            default: return MODE_BYPASS;
        endcase
    endfunction

    // Quarter-wave entry j of n: round(A*sin(pi/2*j/n)), A = 2^(coef_w-1)-1.
    // The end points are pinned so they are exact regardless of libm.
    function automatic int lut_entry(input int j, input int n, input int coef_w);
        real amp;
        real ang;
        amp = real'((1 << (coef_w - 1)) - 1);
        if (j <= 0) begin
            return 0;
        end
        if (j >= n) begin
            return (1 << (coef_w - 1)) - 1;
        end
        ang = 3.141592653589793 / 2.0 * real'(j) / real'(n);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddc_mixer_lanes_nco.sv
`default_nettype none
// ============================================================================
// Module      : nco_lanes
// Description : Phase accumulator with per-lane offsets (k*inc) and a
//               quarter-wave sine LUT. Lane phases are registered with the
//               input beat (S0); cos/sin pairs are registered one cycle later
//               (S1).
// Revision    : 1.0 - initial release
// ============================================================================
module nco_lanes
    import ddc_mixer_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int COEF_W  = 18,
    parameter int LUT_AW  = 10,
    parameter int PHASE_W = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_valid,
    input  logic                      i_phase_sync,
    input  logic [PHASE_W-1:0]        i_phase_inc,
    input  logic                      i_phase_inc_valid,
    output logic [LANES*COEF_W-1:0]   o_cos,
    output logic [LANES*COEF_W-1:0]   o_sin
);

    localparam int c_N   = 1 << LUT_AW;
    localparam int c_TOP = LUT_AW + 2;

    logic [PHASE_W-1:0] r_inc;
    logic [PHASE_W-1:0] r_acc;
    // Entry k holds k*inc; entry LANES is the per-beat accumulator step.
    logic [PHASE_W-1:0] r_offset [0:LANES];
    logic [PHASE_W-1:0] w_base;
    logic [COEF_W-1:0]  w_lut    [0:c_N];

    for (genvar j = 0; j <= c_N; j++) begin : g_lut
        localparam logic [COEF_W-1:0] c_ENTRY = COEF_W'(lut_entry(j, c_N, COEF_W));
        assign w_lut[j] = c_ENTRY;
    end

    // Sync zeroes the base seen by a beat in the same cycle.
    assign w_base = i_phase_sync ? '0 : r_acc;

    // Increment capture; the offsets follow one cycle later, so a beat right
    // after the load still uses the old increment for offsets and step.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_inc <= '0;
            for (int k = 0; k <= LANES; k++) begin
                r_offset[k] <= '0;
            end
        end else begin
            if (i_phase_inc_valid) begin
                r_inc <= i_phase_inc;
            end
            for (int k = 0; k <= LANES; k++) begin
                r_offset[k] <= PHASE_W'(k) * r_inc;
            end
        end
    end

    // Accumulator advances by LANES*inc after each beat has used it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= i_valid ? (w_base + r_offset[LANES]) : w_base;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PHASE_W-1:0] w_phase;
        logic               w_unused_lsbs;
        logic [c_TOP-1:0]   r_top;
        logic [1:0]         w_quad;
        logic [LUT_AW:0]    w_fidx;
        logic [LUT_AW:0]    w_ridx;
        logic [COEF_W-1:0]  w_fwd;
        logic [COEF_W-1:0]  w_rev;
        logic [COEF_W-1:0]  r_cos;
        logic [COEF_W-1:0]  r_sin;

        assign w_phase       = w_base + r_offset[k];
        assign w_unused_lsbs = ^w_phase[PHASE_W-c_TOP-1:0];
        assign w_quad        = r_top[c_TOP-1 -: 2];
        assign w_fidx        = {1'b0, r_top[LUT_AW-1:0]};
        assign w_ridx        = (LUT_AW+1)'(c_N) - w_fidx;
        assign w_fwd         = w_lut[w_fidx];
        assign w_rev         = w_lut[w_ridx];

        // S0: only the quadrant and LUT index of each lane phase are kept.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_top <= '0;
            end else begin
                r_top <= w_phase[PHASE_W-1 -: c_TOP];
            end
        end

        // S1: quadrant fold; cos is sin advanced by one quadrant.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_sin <= '0;
                r_cos <= '0;
            end else begin
                case (w_quad)
                    2'd0: begin r_sin <= w_fwd;  r_cos <= w_rev;  end
                    2'd1: begin r_sin <= w_rev;  r_cos <= -w_fwd; end
                    2'd2: begin r_sin <= -w_fwd; r_cos <= -w_rev; end
                    default: begin r_sin <= -w_rev; r_cos <= w_fwd; end
                endcase
            end
        end

        assign o_cos[k*COEF_W +: COEF_W] = r_cos;
        assign o_sin[k*COEF_W +: COEF_W] = r_sin;
    end

endmodule
`default_nettype wire

// File: rtl/ddc_mixer_lanes.sv
`default_nettype none
// ============================================================================
// Module      : ddc_mixer_lanes
// Description : Multi-lane complex mixer with integrated NCO. Each beat
//               carries LANES complex samples, rotated down, up or bypassed
//               per beat, then rounded to WIDTH. Fixed 5-cycle latency.
//               Optional macro DDC_MIXER_SAT_EN: saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module ddc_mixer_lanes
    import ddc_mixer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LANES   = 4,
    parameter int COEF_W  = 18,
    parameter int LUT_AW  = 10,
    parameter int PHASE_W = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [LANES*WIDTH-1:0]   i_inph_data,
    input  logic [LANES*WIDTH-1:0]   i_quad_data,
    input  logic                     i_valid,
    input  logic [1:0]               i_mode,
    input  logic [PHASE_W-1:0]       i_phase_inc,
    input  logic                     i_phase_inc_valid,
    input  logic                     i_phase_sync,
    output logic [LANES*WIDTH-1:0]   o_inph_data,
    output logic [LANES*WIDTH-1:0]   o_quad_data,
    output logic                     o_valid
);

    localparam int c_PROD_W = WIDTH + COEF_W;
    localparam int c_SUM_W  = c_PROD_W + 1;
    localparam int c_SHIFT  = COEF_W - 1;
    localparam int c_RND_W  = c_SUM_W - c_SHIFT;
    localparam logic signed [c_SUM_W-1:0] c_HALF = c_SUM_W'(1) <<< (COEF_W - 2);

`ifdef DDC_MIXER_SAT_EN
    localparam logic signed [c_RND_W-1:0] c_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_RND_W-1:0] c_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] sat(input logic signed [c_RND_W-1:0] x);
        if (x > c_MAX) begin
            return c_MAX[WIDTH-1:0];
        end else if (x < c_MIN) begin
            return c_MIN[WIDTH-1:0];
        end
        return x[WIDTH-1:0];
    endfunction
`endif

    logic [LANES*WIDTH-1:0]  r0_inph, r0_quad, r1_inph, r1_quad;
    mode_e                   r0_mode, r1_mode, r2_mode;
    logic [LATENCY-1:0]      r_valid_sr;
    logic [LANES*COEF_W-1:0] w_nco_cos, w_nco_sin;

    nco_lanes #(
        .LANES   (LANES),
        .COEF_W  (COEF_W),
        .LUT_AW  (LUT_AW),
        .PHASE_W (PHASE_W)
    ) u_nco (
        .i_clock           (i_clock),
        .i_reset_n         (i_reset_n),
        .i_valid           (i_valid),
        .i_phase_sync      (i_phase_sync),
        .i_phase_inc       (i_phase_inc),
        .i_phase_inc_valid (i_phase_inc_valid),
        .o_cos             (w_nco_cos),
        .o_sin             (w_nco_sin)
    );

    // S0/S1 data and mode alignment with the NCO; valid travels S0..S4.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r0_inph    <= '0;
            r0_quad    <= '0;
            r1_inph    <= '0;
            r1_quad    <= '0;
            r0_mode    <= MODE_DOWN;
            r1_mode    <= MODE_DOWN;
            r2_mode    <= MODE_DOWN;
            r_valid_sr <= '0;
        end else begin
            r0_inph    <= i_inph_data;
            r0_quad    <= i_quad_data;
            r1_inph    <= r0_inph;
            r1_quad    <= r0_quad;
            r0_mode    <= decode_mode(i_mode);
            r1_mode    <= r0_mode;
            r2_mode    <= r1_mode;
            r_valid_sr <= {r_valid_sr[LATENCY-2:0], i_valid};
        end
    end

    assign o_valid = r_valid_sr[LATENCY-1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WIDTH-1:0]    w_inph, w_quad;
        logic signed [COEF_W-1:0]   w_cos, w_sin;
        logic signed [c_PROD_W-1:0] r_ic, r_qs, r_qc, r_is;
        logic signed [c_SUM_W-1:0]  r_isum, r_qsum, w_ibias, w_qbias;
        logic signed [c_RND_W-1:0]  w_irnd, w_qrnd;
        logic [WIDTH-1:0]           w_ifit, w_qfit, r_iout, r_qout;
        logic                       w_unused_bits;

        assign w_inph  = r1_inph[k*WIDTH +: WIDTH];
        assign w_quad  = r1_quad[k*WIDTH +: WIDTH];
        assign w_cos   = w_nco_cos[k*COEF_W +: COEF_W];
        assign w_sin   = w_nco_sin[k*COEF_W +: COEF_W];

        // S2: products; bypass pre-scales the sample so rounding returns it.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_ic <= '0;
                r_qs <= '0;
                r_qc <= '0;
                r_is <= '0;
            end else if (r1_mode == MODE_BYPASS) begin
                r_ic <= c_PROD_W'(w_inph) <<< c_SHIFT;
                r_qs <= '0;
                r_qc <= c_PROD_W'(w_quad) <<< c_SHIFT;
                r_is <= '0;
            end else begin
                r_ic <= c_PROD_W'(w_inph) * c_PROD_W'(w_cos);
                r_qs <= c_PROD_W'(w_quad) * c_PROD_W'(w_sin);
                r_qc <= c_PROD_W'(w_quad) * c_PROD_W'(w_cos);
                r_is <= c_PROD_W'(w_inph) * c_PROD_W'(w_sin);
            end
        end

        // S3: complex combine; bypass shares the down-conversion signs.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_isum <= '0;
                r_qsum <= '0;
            end else if (r2_mode == MODE_UP) begin
                r_isum <= c_SUM_W'(r_ic) - c_SUM_W'(r_qs);
                r_qsum <= c_SUM_W'(r_qc) + c_SUM_W'(r_is);
            end else begin
                r_isum <= c_SUM_W'(r_ic) + c_SUM_W'(r_qs);
                r_qsum <= c_SUM_W'(r_qc) - c_SUM_W'(r_is);
            end
        end

        // Round half up: add half an LSB, drop the fractional bits.
        assign w_ibias = r_isum + c_HALF;
        assign w_qbias = r_qsum + c_HALF;
        assign w_irnd  = w_ibias[c_SUM_W-1:c_SHIFT];
        assign w_qrnd  = w_qbias[c_SUM_W-1:c_SHIFT];

`ifdef DDC_MIXER_SAT_EN
        assign w_ifit        = sat(w_irnd);
        assign w_qfit        = sat(w_qrnd);
        assign w_unused_bits = ^{w_ibias[c_SHIFT-1:0], w_qbias[c_SHIFT-1:0]};
`else
        assign w_ifit        = w_irnd[WIDTH-1:0];
        assign w_qfit        = w_qrnd[WIDTH-1:0];
        assign w_unused_bits = ^{w_ibias[c_SHIFT-1:0], w_qbias[c_SHIFT-1:0],
                                 w_irnd[c_RND_W-1:WIDTH], w_qrnd[c_RND_W-1:WIDTH]};
`endif

        // S4: registered lane outputs.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_iout <= '0;
                r_qout <= '0;
            end else begin
                r_iout <= w_ifit;
                r_qout <= w_qfit;
            end
        end

        assign o_inph_data[k*WIDTH +: WIDTH] = r_iout;
        assign o_quad_data[k*WIDTH +: WIDTH] = r_qout;
    end

endmodule
`default_nettype wire

// File: tb/tb_ddc_mixer_lanes.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ddc_mixer_lanes
// Description : Scoreboard bench for ddc_mixer_lanes. Expected beats are
//               queued when driven and compared when o_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddc_mixer_lanes;

    localparam int WIDTH   = 16;
    localparam int LANES   = 4;
    localparam int COEF_W  = 18;
    localparam int LUT_AW  = 10;
    localparam int PHASE_W = 32;
    localparam int N       = 1 << LUT_AW;
    localparam int LAT     = 5;
    localparam longint AMP = (longint'(1) << (COEF_W - 1)) - 1;

    localparam logic [63:0] ALL1000 = {4{16'h03E8}};
    localparam logic [63:0] QD_I    = {16'h0000, 16'hFC18, 16'h0000, 16'h03E8};
    localparam logic [63:0] QD_Q    = {16'h03E8, 16'h0000, 16'hFC18, 16'h0000};
    localparam logic [63:0] QU_Q    = {16'hFC18, 16'h0000, 16'h03E8, 16'h0000};

    typedef struct packed {
        logic [63:0] i;
        logic [63:0] q;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_i = '0, in_q = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_mode = 2'b00;
    logic [31:0] in_inc = '0;
    logic        in_inc_valid = 1'b0;
    logic        in_sync = 1'b0;
    logic [63:0] out_i, out_q;
    logic        out_valid;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_acc = '0, m_inc_reg = '0, m_inc_off = '0;

    ddc_mixer_lanes #(
        .WIDTH(WIDTH), .LANES(LANES), .COEF_W(COEF_W), .LUT_AW(LUT_AW), .PHASE_W(PHASE_W)
    ) dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_inph_data       (in_i),
        .i_quad_data       (in_q),
        .i_valid           (in_valid),
        .i_mode            (in_mode),
        .i_phase_inc       (in_inc),
        .i_phase_inc_valid (in_inc_valid),
        .i_phase_sync      (in_sync),
        .o_inph_data       (out_i),
        .o_quad_data       (out_q),
        .o_valid           (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint lut_val(input int j);
        if (j == 0) return 0;
        if (j == N) return AMP;
        return longint'($rtoi(real'(AMP) * $sin(3.141592653589793 / 2.0 * real'(j) / real'(N)) + 0.5));
    endfunction

    function automatic longint sin_of(input logic [31:0] p);
        int i;
        i = int'(p[PHASE_W-3 -: LUT_AW]);
        case (p[31:30])
            2'd0:    return lut_val(i);
            2'd1:    return lut_val(N - i);
            2'd2:    return -lut_val(i);
            default: return -lut_val(N - i);
        endcase
    endfunction

    function automatic logic [15:0] fit(input longint v);
        longint r;
        r = (v + 65536) >>> 17;
`ifdef DDC_MIXER_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    // One clock of stimulus; queues the expected beat (model or explicit).
    task automatic step(input logic v, input logic [1:0] md, input logic [63:0] di,
                        input logic [63:0] dq, input logic sync, input logic incv,
                        input logic [31:0] inc, input logic ovr,
                        input logic [63:0] xi, input logic [63:0] xq);
        logic [31:0] base, p;
        longint a, b, c, s;
        exp_t e;
        in_valid = v; in_mode = md; in_i = di; in_q = dq;
        in_sync = sync; in_inc_valid = incv; in_inc = inc;
        base = sync ? 32'd0 : m_acc;
        if (v) begin
            for (int k = 0; k < LANES; k++) begin
                p = base + 32'(k) * m_inc_off;
                a = longint'($signed(di[k*WIDTH +: WIDTH]));
                b = longint'($signed(dq[k*WIDTH +: WIDTH]));
                c = sin_of(p + 32'h4000_0000);
                s = sin_of(p);
                if (md[1]) begin
                    e.i[k*WIDTH +: WIDTH] = di[k*WIDTH +: WIDTH];
                    e.q[k*WIDTH +: WIDTH] = dq[k*WIDTH +: WIDTH];
                end else if (md[0]) begin
                    e.i[k*WIDTH +: WIDTH] = fit(a * c - b * s);
                    e.q[k*WIDTH +: WIDTH] = fit(b * c + a * s);
                end else begin
                    e.i[k*WIDTH +: WIDTH] = fit(a * c + b * s);
                    e.q[k*WIDTH +: WIDTH] = fit(b * c - a * s);
                end
            end
            if (ovr) begin
                e.i = xi;
                e.q = xq;
            end
            e.tag = 32'(cyc);
            sb.push_back(e);
        end
        m_acc     = v ? base + 32'(LANES) * m_inc_off : base;
        m_inc_off = m_inc_reg;
        if (incv) m_inc_reg = inc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic load_inc(input logic [31:0] inc);
        step(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, inc, 1'b0, '0, '0);
    endtask

    // Output monitor: pops and compares each produced beat and its latency.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL stray_beat: got i=%h q=%h, required no beat", out_i, out_q);
            end else begin
                mon_e = sb.pop_front();
                n_cmp++;
                if (out_i !== mon_e.i || out_q !== mon_e.q) begin
                    n_bad++;
                    $display("FAIL beat_data: got i=%h q=%h, required i=%h q=%h",
                             out_i, out_q, mon_e.i, mon_e.q);
                end
                n_cmp++;
                if (cyc - int'(mon_e.tag) !== LAT) begin
                    n_bad++;
                    $display("FAIL latency: got %0d, required %0d", cyc - int'(mon_e.tag), LAT);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b, required 0", out_valid);
        end
        n_cmp++;
        if (out_i !== '0 || out_q !== '0) begin
            n_bad++; $display("FAIL reset_data: got i=%h q=%h, required 0", out_i, out_q);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_zero_inc();
        for (int n = 0; n < 3; n++)
            step(1'b1, 2'b00, ALL1000, '0, 1'b0, 1'b0, '0, 1'b1, ALL1000, '0);
        idle();
    endtask

    task automatic test_quarter();
        load_inc(32'h4000_0000);
        idle();
        step(1'b1, 2'b00, ALL1000, '0, 1'b1, 1'b0, '0, 1'b1, QD_I, QD_Q);
        step(1'b1, 2'b01, ALL1000, '0, 1'b1, 1'b0, '0, 1'b1, QD_I, QU_Q);
    endtask

    task automatic test_bypass();
        logic [63:0] di, dq;
        for (int n = 0; n < 6; n++) begin
            di = {$urandom, $urandom};
            dq = {$urandom, $urandom};
            step(1'b1, (n % 2 == 0) ? 2'b10 : 2'b11, di, dq, 1'b0, 1'b0, '0, 1'b1, di, dq);
        end
        load_inc($urandom);
        idle();
        for (int n = 0; n < 8; n++) begin
            di = {$urandom, $urandom};
            dq = {$urandom, $urandom};
            if (n % 2 == 0) step(1'b1, 2'b00, di, dq, 1'b0, 1'b0, '0, 1'b0, '0, '0);
            else            step(1'b1, 2'b10, di, dq, 1'b0, 1'b0, '0, 1'b1, di, dq);
        end
    endtask

    task automatic test_inc_update();
        load_inc(32'h0);
        idle();
        load_inc(32'h4000_0000);
        step(1'b1, 2'b00, ALL1000, '0, 1'b1, 1'b0, '0, 1'b1, ALL1000, '0);
        step(1'b1, 2'b00, ALL1000, '0, 1'b0, 1'b0, '0, 1'b1, QD_I, QD_Q);
        load_inc($urandom);
        load_inc(32'h4000_0000);
        idle();
        step(1'b1, 2'b00, ALL1000, '0, 1'b1, 1'b0, '0, 1'b1, QD_I, QD_Q);
        for (int n = 0; n < 16; n++)
            step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom,
                 1'b0, '0, '0);
    endtask

    task automatic test_sync_beat();
        load_inc($urandom);
        for (int n = 0; n < 3; n++)
            step(1'b1, 2'b00, ALL1000, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        step(1'b1, 2'b00, ALL1000, '0, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b1, 2'b01, ALL1000, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_saturation();
        load_inc(32'h2000_0000);
        idle();
        step(1'b1, 2'b01, {4{16'h8000}}, {4{16'h8000}}, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b1, 2'b00, {4{16'h7FFF}}, {4{16'h8000}}, 1'b1, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 6; n++)
            step(1'b1, 2'b00, {$urandom, $urandom}, {$urandom, $urandom},
                 1'b0, 1'b0, '0, 1'b0, '0, '0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sync = 1'b0; in_inc_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_valid: got %b, required 0", out_valid);
        end
        n_cmp++;
        if (out_i !== '0 || out_q !== '0) begin
            n_bad++; $display("FAIL async_reset_data: got i=%h q=%h, required 0", out_i, out_q);
        end
        sb.delete();
        m_acc = '0; m_inc_reg = '0; m_inc_off = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_inc(32'h4000_0000);
        idle();
        step(1'b1, 2'b00, ALL1000, '0, 1'b0, 1'b0, '0, 1'b1, QD_I, QD_Q);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            idle();
            budget--;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL drain_timeout: got %0d beats pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_inc();
        test_quarter();
        test_bypass();
        test_inc_update();
        test_sync_beat();
        test_saturation();
        drain();
        test_reset_mid();
        drain();
        repeat (8) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
